// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, forward-select codes
// and the register-match helper used by both hazard detection and forwarding.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic {
    RUN     = 1'b0,
    DM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_DM = 2'b10;

  // A producer hits a consumer only when it writes a real register ($0 never counts).
  function automatic logic reg_hit(
    input logic [REG_AW-1:0] rd,
    input logic              we,
    input logic [REG_AW-1:0] src,
    input logic              used
  );
    return used && we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX operand source select; EX/DM ALU results win over DM/WB.
// Loads in DM are not forwarded from EX/DM since their data is not ready yet.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0] dm_rd,
  input  logic              dm_w_enable,
  input  logic              dm_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_w_enable,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(dm_rd, dm_w_enable && !dm_is_load, ex_src, 1'b1)) begin
      sel = FWD_DM;
    end else if (reg_hit(wb_rd, wb_w_enable, ex_src, 1'b1)) begin
      sel = FWD_WB;
    end
    if (!EN) begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: DM wait freeze, load-use stall, branch flush, forwarding.
// Define HAZ_FWD_EN to enable forwarding; otherwise every RAW hazard stalls ID.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DM_TIMEOUT = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_w_enable,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] dm_rd,
  input  logic              dm_w_enable,
  input  logic              dm_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_w_enable,
  input  logic              dm_req,
  input  logic              dm_ready,
  input  logic              branch_taken,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_dm_stall,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              dm_wb_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              dm_err,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef HAZ_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam int WAIT_W = $clog2(DM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              dm_err_q, dm_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [REG_AW-1:0] prod_rd [3];
  logic [2:0]        prod_we;
  logic [2:0]        prod_hit;
  logic              load_use;
  logic              id_hazard;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign prod_rd[0] = ex_rd;
  assign prod_rd[1] = dm_rd;
  assign prod_rd[2] = wb_rd;
  assign prod_we    = {wb_w_enable, dm_w_enable, ex_w_enable};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_prod
      assign prod_hit[gi] = reg_hit(prod_rd[gi], prod_we[gi], id_rs, id_uses_rs) ||
                            reg_hit(prod_rd[gi], prod_we[gi], id_rt, id_uses_rt);
    end
  endgenerate

  // With forwarding only a load in EX is too late; without it any pending write stalls.
  assign load_use  = ex_is_load && prod_hit[0];
  assign id_hazard = FWD_EN ? load_use : (|prod_hit);

  fwd_unit #(.EN(FWD_EN)) u_fwd_a (
    .ex_src      (ex_rs),
    .dm_rd       (dm_rd),
    .dm_w_enable (dm_w_enable),
    .dm_is_load  (dm_is_load),
    .wb_rd       (wb_rd),
    .wb_w_enable (wb_w_enable),
    .sel         (fwd_a_raw)
  );

  fwd_unit #(.EN(FWD_EN)) u_fwd_b (
    .ex_src      (ex_rt),
    .dm_rd       (dm_rd),
    .dm_w_enable (dm_w_enable),
    .dm_is_load  (dm_is_load),
    .wb_rd       (wb_rd),
    .wb_w_enable (wb_w_enable),
    .sel         (fwd_b_raw)
  );

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_dm_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    dm_wb_bubble = 1'b0;
    fwd_a_sel    = FWD_RF;
    fwd_b_sel    = FWD_RF;
    if (rst_n) begin
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;
      // The memory freeze holds EX, so a pending branch is simply seen again after it.
      if (state_q == DM_WAIT) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_dm_stall  = 1'b1;
        dm_wb_bubble = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (id_hazard) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    dm_err_d    = dm_err_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (dm_req && !dm_ready) begin
          state_d = DM_WAIT;
          wait_d  = '0;
        end
      end
      DM_WAIT: begin
        if (dm_ready) begin
          state_d = RUN;
        end else if (wait_q == WAIT_W'(DM_TIMEOUT - 1)) begin
          state_d  = RUN;
          dm_err_d = 1'b1;
        end else begin
          wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = RUN;
    endcase
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      dm_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      dm_err_q    <= dm_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dm_err    = dm_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
